// File: rtl/top_entity_pkg.sv
// Shared definitions for the board counter slice.
//   CLK_HZ            - board clock frequency in Hz
//   CNT_W             - counter / display width
//   seg7_t            - active-low seven-segment pattern {g,f,e,d,c,b,a}
//   SEG_ZERO, SEG_ONE - glyphs for a binary '0' and '1'
//   bin2gray()        - natural binary to reflected Gray code
package top_entity_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned CNT_W  = 5;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_ZERO = 7'b1000000;
    localparam seg7_t SEG_ONE  = 7'b1111001;

    function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sync_clock_gen.sv
// Divides the 50 MHz board clock down to the sync (count) clock.
// Parameter:
//   Frequency    - sync clock rate in Hz, 1..25_000_000
// Ports:
//   i_clock_50mhz - board clock, rising edge
//   i_reset       - asynchronous active-high reset
//   o_sync_clock  - divided clock, 50 % duty, period 1/Frequency
//   o_tick        - one-cycle pulse in the cycle where o_sync_clock goes 0->1
module sync_clock_gen
    import top_entity_pkg::*;
#(
    parameter int unsigned Frequency = 1
) (
    input  logic i_clock_50mhz,
    input  logic i_reset,
    output logic o_sync_clock,
    output logic o_tick
);

    localparam logic [31:0] HALF = 32'(CLK_HZ / (2 * Frequency));

    logic [31:0] div;
    logic        sync_q;
    logic        wrap;

    assign wrap = (div == HALF - 32'd1);

    always_ff @(posedge i_clock_50mhz or posedge i_reset) begin
        if (i_reset) begin
            div    <= '0;
            sync_q <= 1'b0;
        end else if (wrap) begin
            div    <= '0;
            sync_q <= ~sync_q;
        end else begin
            div    <= div + 32'd1;
        end
    end

    assign o_sync_clock = sync_q;
    // Tick is decoded from the current state so the counter steps on the
    // same edge that raises o_sync_clock.
    assign o_tick       = wrap && !sync_q;

endmodule

// File: rtl/top_entity.sv
// Board counter top level: 5-bit up/down counter stepped by the sync clock,
// shown as binary or Gray on 5 LEDs and five 7-segment displays (one bit each).
// Build option: define COUNTER_SATURATE_EN to saturate at 0/31 instead of wrapping.
// Parameters:
//   Frequency - sync clock rate in Hz, 1..25_000_000
//   Initial   - value loaded while i_set is high
// Ports:
//   i_clock_50mhz - board clock, rising edge
//   i_reset       - asynchronous active-high reset
//   i_set         - load Initial (level, highest priority)
//   i_pause       - 1 = hold counter
//   i_count       - direction, 1 = up, 0 = down
//   i_type        - 0 = binary, 1 = Gray output code
//   o_HEXs        - active-low digits, o_HEXs[4] = MSB
//   o_LEDs        - displayed code, bit 4 = MSB
//   o_sync_clock  - divided clock
module top_entity
    import top_entity_pkg::*;
#(
    parameter int unsigned      Frequency = 1,
    parameter logic [CNT_W-1:0] Initial   = 5'b01001
) (
    input  logic       i_clock_50mhz,
    input  logic       i_reset,
    input  logic       i_set,
    input  logic       i_pause,
    input  logic       i_count,
    input  logic       i_type,
    output logic [6:0] o_HEXs [4:0],
    output logic [4:0] o_LEDs,
    output logic       o_sync_clock
);

    logic             tick;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] code;

    sync_clock_gen #(
        .Frequency (Frequency)
    ) u_sync_clock_gen (
        .i_clock_50mhz (i_clock_50mhz),
        .i_reset       (i_reset),
        .o_sync_clock  (o_sync_clock),
        .o_tick        (tick)
    );

    always_ff @(posedge i_clock_50mhz or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (i_set) begin
            cnt <= Initial;
        end else if (i_pause) begin
            cnt <= cnt;
        end else if (tick) begin
`ifdef COUNTER_SATURATE_EN
            if (i_count && cnt != '1)
                cnt <= cnt + 1'b1;
            else if (!i_count && cnt != '0)
                cnt <= cnt - 1'b1;
`else
            cnt <= i_count ? cnt + 1'b1 : cnt - 1'b1;
`endif
        end
    end

    assign code   = i_type ? bin2gray(cnt) : cnt;
    assign o_LEDs = code;

    always_comb begin
        for (int unsigned k = 0; k < CNT_W; k++) begin
            o_HEXs[k] = code[k] ? SEG_ONE : SEG_ZERO;
        end
    end

endmodule

// File: tb/tb_top_entity.sv
// Directed, table-driven bench for top_entity at Frequency = 1 MHz (HALF = 25).
module tb_top_entity;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;

`ifdef COUNTER_SATURATE_EN
    localparam logic [4:0] WRAP_DN = 5'd0;
    localparam logic [4:0] WRAP_UP = 5'd31;
    localparam logic [4:0] G_DN    = 5'b00000;  // gray(0)
    localparam logic [4:0] G_UP    = 5'b10000;  // gray(31)
`else
    localparam logic [4:0] WRAP_DN = 5'd31;
    localparam logic [4:0] WRAP_UP = 5'd0;
    localparam logic [4:0] G_DN    = 5'b10000;
    localparam logic [4:0] G_UP    = 5'b00000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       set, pause, count, typ;
    logic [6:0] hexs [4:0];
    logic [4:0] leds;
    logic       sync;

    int checks = 0;
    int errors = 0;

    top_entity #(
        .Frequency (1_000_000),
        .Initial   (5'b01001)
    ) dut (
        .i_clock_50mhz (clk),
        .i_reset       (rst),
        .i_set         (set),
        .i_pause       (pause),
        .i_count       (count),
        .i_type        (typ),
        .o_HEXs        (hexs),
        .o_LEDs        (leds),
        .o_sync_clock  (sync)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       set;
        logic       pause;
        logic       count;
        logic       typ;
        int         ticks;   // -1: check 1 ns after applying, 0: one clock, N: N sync rises
        logic [4:0] exp_leds;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge that sees sync risen.
    task automatic wait_rise(output bit ok);
        logic prev;
        prev = sync;
        ok   = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!prev && sync) begin
                ok = 1'b1;
                return;
            end
            prev = sync;
        end
    endtask

    // Negedges from the current one until sync equals lvl (bounded).
    task automatic cycles_until(input logic lvl, output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (sync === lvl) return;
        end
    endtask

    task automatic run_vec(input int i);
        bit ok;
        set   = vecs[i].set;
        pause = vecs[i].pause;
        count = vecs[i].count;
        typ   = vecs[i].typ;
        if (vecs[i].ticks < 0) begin
            #1;
        end else if (vecs[i].ticks == 0) begin
            @(negedge clk);
        end else begin
            for (int t = 0; t < vecs[i].ticks; t++) begin
                wait_rise(ok);
                check($sformatf("vec%0d_sync_rise", i), 32'(ok), 32'd1);
                if (!ok) break;
            end
        end
        check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
    endtask

    initial begin
        int n, hi, lo;
        bit ok;

        vecs[0]  = '{0, 0, 1, 0,  1, 5'd1};
        vecs[1]  = '{0, 0, 1, 0,  1, 5'd2};
        vecs[2]  = '{0, 0, 1, 0,  3, 5'd5};
        vecs[3]  = '{1, 0, 1, 0,  0, 5'd9};      // set loads on next edge
        vecs[4]  = '{1, 0, 1, 0,  2, 5'd9};      // held across ticks
        vecs[5]  = '{0, 0, 1, 0,  3, 5'd12};     // resumes from 9
        vecs[6]  = '{0, 1, 1, 0, 20, 5'd12};     // pause 20 periods
        vecs[7]  = '{1, 0, 0, 0,  0, 5'd9};
        vecs[8]  = '{0, 0, 0, 0,  1, 5'd8};      // down
        vecs[9]  = '{0, 0, 0, 1, -1, 5'b01100};  // gray(8), zero latency
        vecs[10] = '{0, 0, 0, 0,  8, 5'd0};
        vecs[11] = '{0, 0, 0, 0,  1, WRAP_DN};
        vecs[12] = '{0, 0, 0, 1, -1, G_DN};
        vecs[13] = '{1, 0, 1, 0,  0, 5'd9};
        vecs[14] = '{0, 0, 1, 0, 22, 5'd31};
        vecs[15] = '{0, 0, 1, 0,  1, WRAP_UP};
        vecs[16] = '{0, 1, 0, 1, -1, G_UP};

        rst = 1'b1; set = 1'b0; pause = 1'b1; count = 1'b1; typ = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_sync", 32'(sync), 32'd0);
        for (int k = 0; k < 5; k++)
            check($sformatf("rst_hex%0d", k), 32'(hexs[k]), 32'(H0));

        // Divider timing, counter paused at 0
        rst = 1'b0;
        cycles_until(1'b1, n);
        check("first_rise_cycles", 32'(n), 32'd25);
        cycles_until(1'b0, hi);
        check("high_cycles", 32'(hi), 32'd25);
        cycles_until(1'b1, lo);
        check("period_cycles", 32'(hi + lo), 32'd50);
        check("paused_leds", 32'(leds), 32'd0);

        for (int i = 0; i <= 9; i++) run_vec(i);
        // gray 01100 -> digits MSB..LSB '0','1','1','0','0'
        check("gray_hex4", 32'(hexs[4]), 32'(H0));
        check("gray_hex3", 32'(hexs[3]), 32'(H1));
        check("gray_hex2", 32'(hexs[2]), 32'(H1));
        check("gray_hex1", 32'(hexs[1]), 32'(H0));
        check("gray_hex0", 32'(hexs[0]), 32'(H0));
        for (int i = 10; i < 17; i++) run_vec(i);

        // Asynchronous reset mid-count, with set held high
        @(negedge clk);
        set = 1'b1; pause = 1'b0; count = 1'b1; typ = 1'b0;
        wait_rise(ok);
        check("pre_rst_rise", 32'(ok), 32'd1);
        check("pre_rst_leds", 32'(leds), 32'd9);
        #3 rst = 1'b1;
        #1;
        check("async_rst_leds", 32'(leds), 32'd0);
        check("async_rst_sync", 32'(sync), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_set_leds", 32'(leds), 32'd0);
        check("rst_hold_hex3", 32'(hexs[3]), 32'(H0));
        set = 1'b0; pause = 1'b1;
        rst = 1'b0;
        cycles_until(1'b1, n);
        check("rerst_first_rise", 32'(n), 32'd25);
        check("rerst_leds", 32'(leds), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
